// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the TX serializer: FSM state encodings and byte-order selectors.
package sys_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SEND     = 2'b01,
        ST_WAIT_LOW = 2'b10
    } tx_state_e;

    localparam int BYTE_ORDER_LSB_FIRST = 0;
    localparam int BYTE_ORDER_MSB_FIRST = 1;

endpackage

// File: rtl/sys_tx_req_slot.sv
// One-deep pending request slot: captures a request pulse with its data, holds it until
// the serializer consumes it, and flags requests that arrive while it is still occupied.
module sys_tx_req_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_i,
    input  logic [DW-1:0] data_i,
    input  logic          consume_i,
    output logic          full_o,
    output logic [DW-1:0] data_o,
    output logic          drop_o
);

    logic          full_q, full_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] data_q, data_d;

    // Next-state: a consume in the same cycle frees the slot so a new request can refill it.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        drop_d = 1'b0;
        if (req_i && (!full_q || consume_i)) begin
            full_d = 1'b1;
            data_d = data_i;
        end else begin
            if (consume_i) begin
                full_d = 1'b0;
            end
            if (req_i) begin
                drop_d = 1'b1;
            end
        end
    end

    // Control flags carry the reset; requests during reset are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            full_q <= full_d;
            drop_q <= drop_d;
        end
    end

    // Held data needs no reset: it is only observed while full_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign drop_o = drop_q;

endmodule

// File: rtl/sys_tx_serializer.sv
// Serializes register-file bytes and multi-byte ALU results onto a byte-wide UART
// handshake (valid out, busy in), with per-source pending slots and a SEND timeout.
module sys_tx_serializer
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ALU_BYTES  = 2,
    parameter int BYTE_ORDER = 0,
    parameter int TIMEOUT    = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uart_rf_send_in,
    input  logic [WIDTH-1:0]           uart_rf_send_data_in,
    input  logic                       uart_alu_send_in,
    input  logic [ALU_BYTES*WIDTH-1:0] uart_alu_send_data_in,
    input  logic                       uart_tx_busy_in,
    output logic [WIDTH-1:0]           uart_tx_data_out,
    output logic                       uart_tx_data_valid_out,
    output logic                       ctrl_busy_out,
    output logic                       ctrl_drop_out,
    output logic                       ctrl_timeout_out
);

    localparam int FW = ALU_BYTES * WIDTH;
    localparam int IW = $clog2(ALU_BYTES + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    tx_state_e         state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     len_q, len_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              to_q, to_d;

    logic              rf_full, rf_drop, rf_take;
    logic [WIDTH-1:0]  rf_hold;
    logic              alu_full, alu_drop, alu_take;
    logic [FW-1:0]     alu_hold;
    logic [FW-1:0]     alu_ordered;
    logic [WIDTH-1:0]  tx_data;
    logic              tx_valid;

    sys_tx_req_slot #(.DW(WIDTH)) u_rf_slot (
        .clk       (clk),
        .reset     (reset),
        .req_i     (uart_rf_send_in),
        .data_i    (uart_rf_send_data_in),
        .consume_i (rf_take),
        .full_o    (rf_full),
        .data_o    (rf_hold),
        .drop_o    (rf_drop)
    );

    sys_tx_req_slot #(.DW(FW)) u_alu_slot (
        .clk       (clk),
        .reset     (reset),
        .req_i     (uart_alu_send_in),
        .data_i    (uart_alu_send_data_in),
        .consume_i (alu_take),
        .full_o    (alu_full),
        .data_o    (alu_hold),
        .drop_o    (alu_drop)
    );

    // Arrange the ALU frame so the byte to send first always sits in the low byte.
    always_comb begin
        alu_ordered = '0;
        for (int b = 0; b < ALU_BYTES; b++) begin
            if (BYTE_ORDER == BYTE_ORDER_MSB_FIRST) begin
                alu_ordered[b*WIDTH +: WIDTH] = alu_hold[(ALU_BYTES-1-b)*WIDTH +: WIDTH];
            end else begin
                alu_ordered[b*WIDTH +: WIDTH] = alu_hold[b*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and output decode; RF has priority over ALU when both are pending.
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        to_d     = 1'b0;
        rf_take  = 1'b0;
        alu_take = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (!uart_tx_busy_in) begin
                    if (rf_full) begin
                        rf_take             = 1'b1;
                        frame_d             = '0;
                        frame_d[WIDTH-1:0]  = rf_hold;
                        len_d               = IW'(1);
                        state_d             = ST_SEND;
                    end else if (alu_full) begin
                        alu_take = 1'b1;
                        frame_d  = alu_ordered;
                        len_d    = IW'(ALU_BYTES);
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = frame_q[WIDTH-1:0];
                if (uart_tx_busy_in) begin
                    idx_d   = idx_q + IW'(1);
                    frame_d = frame_q >> WIDTH;
                    state_d = ST_WAIT_LOW;
                end else if ((TIMEOUT > 0) && ((cnt_q + TW'(1)) == TW'(TIMEOUT))) begin
                    to_d    = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (!uart_tx_busy_in) begin
                    cnt_d   = '0;
                    state_d = (idx_q == len_q) ? ST_IDLE : ST_SEND;
                end
            end
            default: begin
                idx_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Frame shift register; contents only matter while a frame is in flight.
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign uart_tx_data_out       = tx_data;
    assign uart_tx_data_valid_out = tx_valid;
    assign ctrl_busy_out          = (state_q != ST_IDLE) || rf_full || alu_full;
    assign ctrl_drop_out          = rf_drop || alu_drop;
    assign ctrl_timeout_out       = to_q;

endmodule

// File: tb/tb_sys_tx_serializer.sv
// Bench for sys_tx_serializer: a cycle table on a 2-byte LSB-first instance, then
// hand-written sequences for latency, byte order, arbitration, timeout and mid-frame reset.
module tb_sys_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rf_send, alu_send, busy_in;
    logic [7:0]  rf_data;
    logic [15:0] alu_data2;
    logic [31:0] alu_data4;

    logic [7:0]  dat_o  [3];
    logic        vld_o  [3];
    logic        cb_o   [3];
    logic        drop_o [3];
    logic        to_o   [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drop_cnt [3];
    int to_cnt   [3];

    always #5 clk = ~clk;

    sys_tx_serializer #(.WIDTH(8), .ALU_BYTES(2), .BYTE_ORDER(0), .TIMEOUT(8)) dut_lsb (
        .clk(clk), .reset(reset),
        .uart_rf_send_in(rf_send), .uart_rf_send_data_in(rf_data),
        .uart_alu_send_in(alu_send), .uart_alu_send_data_in(alu_data2),
        .uart_tx_busy_in(busy_in),
        .uart_tx_data_out(dat_o[0]), .uart_tx_data_valid_out(vld_o[0]),
        .ctrl_busy_out(cb_o[0]), .ctrl_drop_out(drop_o[0]), .ctrl_timeout_out(to_o[0])
    );

    sys_tx_serializer #(.WIDTH(8), .ALU_BYTES(2), .BYTE_ORDER(1), .TIMEOUT(8)) dut_msb (
        .clk(clk), .reset(reset),
        .uart_rf_send_in(rf_send), .uart_rf_send_data_in(rf_data),
        .uart_alu_send_in(alu_send), .uart_alu_send_data_in(alu_data2),
        .uart_tx_busy_in(busy_in),
        .uart_tx_data_out(dat_o[1]), .uart_tx_data_valid_out(vld_o[1]),
        .ctrl_busy_out(cb_o[1]), .ctrl_drop_out(drop_o[1]), .ctrl_timeout_out(to_o[1])
    );

    sys_tx_serializer #(.WIDTH(8), .ALU_BYTES(4), .BYTE_ORDER(0), .TIMEOUT(8)) dut_quad (
        .clk(clk), .reset(reset),
        .uart_rf_send_in(rf_send), .uart_rf_send_data_in(rf_data),
        .uart_alu_send_in(alu_send), .uart_alu_send_data_in(alu_data4),
        .uart_tx_busy_in(busy_in),
        .uart_tx_data_out(dat_o[2]), .uart_tx_data_valid_out(vld_o[2]),
        .ctrl_busy_out(cb_o[2]), .ctrl_drop_out(drop_o[2]), .ctrl_timeout_out(to_o[2])
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                drop_cnt[i] <= 0;
                to_cnt[i]   <= 0;
            end else begin
                if (drop_o[i]) drop_cnt[i] <= drop_cnt[i] + 1;
                if (to_o[i])   to_cnt[i]   <= to_cnt[i] + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic        rf;
        logic [7:0]  rfd;
        logic        alu;
        logic [15:0] alud;
        logic        busy;
        logic        ev;
        logic [7:0]  ed;
        logic        ecb;
        logic        edrop;
        logic        eto;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rf, input logic [7:0] rfd, input logic alu,
                                input logic [15:0] alud, input logic busy, input logic ev,
                                input logic [7:0] ed, input logic ecb, input logic edrop,
                                input logic eto);
        vec_t v;
        v.rf = rf; v.rfd = rfd; v.alu = alu; v.alud = alud; v.busy = busy;
        v.ev = ev; v.ed = ed; v.ecb = ecb; v.edrop = edrop; v.eto = eto;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rf_send  = 1'b0;
        alu_send = 1'b0;
        busy_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Wait for a valid byte on instance s, then raise busy dly cycles later for hold cycles.
    task automatic serve(input int s, input int dly, input int hold, input string tag,
                         output logic [7:0] b, output int vc);
        int n;
        n  = 0;
        b  = 8'h00;
        vc = -1;
        do begin
            @(negedge clk);
            n++;
        end while (vld_o[s] !== 1'b1 && n < 60);
        if (vld_o[s] !== 1'b1) begin
            check({tag, "_valid_wait"}, 32'(vld_o[s]), 32'd1);
            return;
        end
        b  = dat_o[s];
        vc = cyc;
        repeat (dly) @(posedge clk);
        #1 busy_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_waitlow_valid"}, 32'(vld_o[s]), 32'd0);
        check({tag, "_waitlow_data"}, 32'(dat_o[s]), 32'd0);
        repeat (hold - 1) @(posedge clk);
        #1 busy_in = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int         vc;
        int         n0;
        int         sc;
        int         vcount;

        rf_data   = 8'h00;
        alu_data2 = 16'h0000;
        alu_data4 = 32'h0;

        // Reset state
        reset = 1'b1; rf_send = 1'b0; alu_send = 1'b0; busy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(vld_o[0]), 32'd0);
        check("rst_data", 32'(dat_o[0]), 32'd0);
        check("rst_busy", 32'(cb_o[0]), 32'd0);
        check("rst_drop", 32'(drop_o[0]), 32'd0);
        check("rst_timeout", 32'(to_o[0]), 32'd0);
        reset = 1'b0;

        // Cycle table on the 2-byte LSB-first instance
        vecs.push_back(mk(1, 8'hA5, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(1, 8'h3C, 0, 16'h0000, 0, 1, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(1, 8'h77, 0, 16'h0000, 1, 1, 8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1, 1, 8'h3C, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 16'h1234, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 16'hBEEF, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1, 1, 8'h34, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1, 1, 8'h12, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1, 1, 8'hEF, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 1, 1, 8'hBE, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rf_send   = vecs[i].rf;
            rf_data   = vecs[i].rfd;
            alu_send  = vecs[i].alu;
            alu_data2 = vecs[i].alud;
            busy_in   = vecs[i].busy;
            @(negedge clk);
            check($sformatf("row%0d_valid", i), 32'(vld_o[0]), 32'(vecs[i].ev));
            check($sformatf("row%0d_data", i), 32'(dat_o[0]), 32'(vecs[i].ed));
            check($sformatf("row%0d_busy", i), 32'(cb_o[0]), 32'(vecs[i].ecb));
            check($sformatf("row%0d_drop", i), 32'(drop_o[0]), 32'(vecs[i].edrop));
            check($sformatf("row%0d_timeout", i), 32'(to_o[0]), 32'(vecs[i].eto));
        end
        @(posedge clk);
        #1 rf_send = 1'b0; alu_send = 1'b0; busy_in = 1'b0;

        // Single RF byte: latency N+2, busy 3 cycles after valid for 10 cycles
        do_reset();
        @(posedge clk);
        #1 rf_send = 1'b1; rf_data = 8'hA5; n0 = cyc;
        @(posedge clk);
        #1 rf_send = 1'b0;
        serve(0, 3, 10, "rf1", b, vc);
        check("rf1_byte", 32'(b), 32'hA5);
        check("rf1_latency", 32'(vc - n0), 32'd2);
        @(negedge clk);
        @(negedge clk);
        check("rf1_idle_busy", 32'(cb_o[0]), 32'd0);
        vcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vld_o[0]) vcount++;
        end
        check("rf1_no_extra_bytes", 32'(vcount), 32'd0);

        // ALU frame 0x1234, LSB first then MSB first
        for (int s = 0; s < 2; s++) begin
            do_reset();
            @(posedge clk);
            #1 alu_send = 1'b1; alu_data2 = 16'h1234;
            @(posedge clk);
            #1 alu_send = 1'b0;
            serve(s, 2, 3, $sformatf("alu%0d_b0", s), b, vc);
            check($sformatf("alu%0d_byte0", s), 32'(b), (s == 0) ? 32'h34 : 32'h12);
            serve(s, 2, 3, $sformatf("alu%0d_b1", s), b, vc);
            check($sformatf("alu%0d_byte1", s), 32'(b), (s == 0) ? 32'h12 : 32'h34);
        end

        // Simultaneous RF and ALU requests: RF first, no drop
        do_reset();
        @(posedge clk);
        #1 rf_send = 1'b1; rf_data = 8'h5A; alu_send = 1'b1; alu_data2 = 16'h1234;
        @(posedge clk);
        #1 rf_send = 1'b0; alu_send = 1'b0;
        serve(0, 1, 2, "arb_b0", b, vc);
        check("arb_byte0", 32'(b), 32'h5A);
        serve(0, 1, 2, "arb_b1", b, vc);
        check("arb_byte1", 32'(b), 32'h34);
        serve(0, 1, 2, "arb_b2", b, vc);
        check("arb_byte2", 32'(b), 32'h12);
        @(negedge clk);
        check("arb_drop_count", 32'(drop_cnt[0]), 32'd0);

        // Timeout: SEND held for 8 cycles, abort, pending frame follows
        do_reset();
        @(posedge clk);
        #1 rf_send = 1'b1; rf_data = 8'h11;
        @(posedge clk);
        #1 rf_send = 1'b0;
        @(posedge clk);
        #1 rf_send = 1'b1; rf_data = 8'h22;
        @(negedge clk);
        check("to_first_valid", 32'(vld_o[0]), 32'd1);
        sc = 1;
        @(posedge clk);
        #1 rf_send = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vld_o[0]) sc++;
            else break;
        end
        check("to_send_cycles", 32'(sc), 32'd8);
        check("to_pulse", 32'(to_o[0]), 32'd1);
        serve(0, 2, 2, "to_next", b, vc);
        check("to_next_byte", 32'(b), 32'h22);
        @(negedge clk);
        check("to_pulse_count", 32'(to_cnt[0]), 32'd1);
        check("to_drop_count", 32'(drop_cnt[0]), 32'd0);

        // Reset during byte 2 of a 4-byte frame
        do_reset();
        @(posedge clk);
        #1 alu_send = 1'b1; alu_data4 = 32'hDDCCBBAA;
        @(posedge clk);
        #1 alu_send = 1'b0;
        serve(2, 1, 2, "rst4_b0", b, vc);
        check("rst4_byte0", 32'(b), 32'hAA);
        n0 = 0;
        do begin
            @(negedge clk);
            n0++;
        end while (vld_o[2] !== 1'b1 && n0 < 40);
        check("rst4_byte1", 32'(dat_o[2]), 32'hBB);
        reset = 1'b1; rf_send = 1'b1; rf_data = 8'h99;
        @(posedge clk);
        #1;
        check("rst4_valid", 32'(vld_o[2]), 32'd0);
        check("rst4_data", 32'(dat_o[2]), 32'd0);
        check("rst4_busy", 32'(cb_o[2]), 32'd0);
        check("rst4_drop", 32'(drop_o[2]), 32'd0);
        check("rst4_timeout", 32'(to_o[2]), 32'd0);
        reset = 1'b0; rf_send = 1'b0;
        @(negedge clk);
        check("rst4_req_ignored", 32'(cb_o[2]), 32'd0);
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vld_o[2]) vcount++;
        end
        check("rst4_no_more_bytes", 32'(vcount), 32'd0);
        check("rst4_drop_count", 32'(drop_cnt[2]), 32'd0);
        check("rst4_timeout_count", 32'(to_cnt[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
